ps2_key_decoder: RTL and testbench

- Upstream input stage for the 2048 game. Receives PS/2 keyboard frames on PS2C/PS2D and decodes scan-code set 2 into one-cycle direction pulses for the game logic, plus mode-key bytes for the mode/interaction logic.
- Replaces the loose keyboard handling with a framed, parity-checked, break-aware decoder running on the 100 MHz system clock.

---
 rtl/ps2_pkg.sv | 66 ++++++
 rtl/ps2_rx_frame.sv | 139 +++++++++++++
 rtl/ps2_key_decoder.sv | 134 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: scan codes (set 2),
// direction bit indices, frame FSM encoding and small decode/parity helpers.
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Plain WASD keys
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    // Bit positions inside the one-hot direction vector
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // Frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Data byte plus parity bit must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Map a make/break code to its one-hot direction; arrows need the E0
    // prefix, WASD must arrive without it. Anything else yields 4'b0000.
    function automatic logic [3:0] dir_decode(input logic [7:0] code,
                                              input logic       ext);
        logic [3:0] d;
        d = 4'b0000;
        if (ext) begin
            case (code)
                SC_UP:    d[DIR_UP]    = 1'b1;
                SC_DOWN:  d[DIR_DOWN]  = 1'b1;
                SC_LEFT:  d[DIR_LEFT]  = 1'b1;
                SC_RIGHT: d[DIR_RIGHT] = 1'b1;
                default:  d = 4'b0000;
            endcase
        end else begin
            case (code)
                SC_W:     d[DIR_UP]    = 1'b1;
                SC_S:     d[DIR_DOWN]  = 1'b1;
                SC_A:     d[DIR_LEFT]  = 1'b1;
                SC_D:     d[DIR_RIGHT] = 1'b1;
                default:  d = 4'b0000;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises PS2C/PS2D, glitch-filters the clock,
// shifts in the 11-bit frame on filtered falling edges, checks start, parity
// and stop, and aborts a stalled frame with a watchdog.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int             FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0]  FILT_MAX = FW'(FILTER_LEN - 1);
    localparam int             WW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0]  WD_MAX   = WW'(TIMEOUT_CYC);

    logic          c_meta_q, c_sync_q;
    logic          d_meta_q, d_sync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    rx_state_e     state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [WW-1:0] wd_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          err_q;

    logic          fedge_s;
    logic          wd_expire_s;

    // Two-flop synchronisers; the idle bus level is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2c_i;
            c_sync_q <= c_meta_q;
            d_meta_q <= ps2d_i;
            d_sync_q <= d_meta_q;
        end
    end

    // Glitch filter: accept a new PS2C level only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (c_sync_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FILT_MAX) begin
            filt_q <= c_sync_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // The filtered clock is about to flip from 1 to 0 on this edge.
    assign fedge_s     = filt_q & ~c_sync_q & (fcnt_q == FILT_MAX);
    assign wd_expire_s = (state_q != ST_IDLE) && (wd_q == WD_MAX);

    // Frame FSM with watchdog; a fedge always wins over an expiring watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
            wd_q     <= '0;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (fedge_s) begin
                wd_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!d_sync_q) begin
                            state_q  <= ST_DATA;
                            bitcnt_q <= 3'd0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg_q  <= {d_sync_q, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= d_sync_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (d_sync_q && odd_parity_ok({par_q, shreg_q})) begin
                            byte_q  <= shreg_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (wd_expire_s) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b1;
                wd_q    <= '0;
            end else if (state_q != ST_IDLE) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder for the 2048 game: turns received bytes into
// one-cycle direction pulses and mode-key updates, tracking E0/F0 prefixes.
// Optional build macro TYPEMATIC_SUPPRESS_EN drops repeated direction makes
// until the matching break arrives.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [3:0] dir,
    output logic [7:0] mode_key,
    output logic       mode_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_err_s;

    logic       e0_q, e0_d;
    logic       f0_q, f0_d;
    logic [3:0] dir_q, dir_d;
    logic [7:0] mode_key_q, mode_key_d;
    logic       mode_valid_q, mode_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [3:0] dec_s;
`ifdef TYPEMATIC_SUPPRESS_EN
    logic [3:0] held_q, held_d;
`endif

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2c_i       (PS2C),
        .ps2d_i       (PS2D),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .err_o        (rx_err_s)
    );

    assign dec_s = dir_decode(rx_byte_s, e0_q);

    // Byte layer: prefix tracking, break handling and make decoding.
    always_comb begin
        e0_d         = e0_q;
        f0_d         = f0_q;
        dir_d        = 4'b0000;
        mode_key_d   = mode_key_q;
        mode_valid_d = 1'b0;
        frame_err_d  = rx_err_s;
`ifdef TYPEMATIC_SUPPRESS_EN
        held_d       = held_q;
`endif
        if (rx_valid_s) begin
            if (rx_byte_s == SC_E0) begin
                e0_d = 1'b1;
            end else if (rx_byte_s == SC_F0) begin
                f0_d = 1'b1;
            end else begin
                if (f0_q) begin
`ifdef TYPEMATIC_SUPPRESS_EN
                    held_d = held_q & ~dec_s;
`else
                    dir_d = 4'b0000;
`endif
                end else if (dec_s != 4'b0000) begin
`ifdef TYPEMATIC_SUPPRESS_EN
                    if ((held_q & dec_s) == 4'b0000) begin
                        dir_d  = dec_s;
                        held_d = held_q | dec_s;
                    end else begin
                        dir_d = 4'b0000;
                    end
`else
                    dir_d = dec_s;
`endif
                end else if (!e0_q) begin
                    mode_key_d   = rx_byte_s;
                    mode_valid_d = 1'b1;
                end else begin
                    mode_valid_d = 1'b0;
                end
                e0_d = 1'b0;
                f0_d = 1'b0;
            end
        end else begin
            dir_d = 4'b0000;
        end
    end

    // Register byte-layer state and all outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q         <= 1'b0;
            f0_q         <= 1'b0;
            dir_q        <= 4'b0000;
            mode_key_q   <= 8'h00;
            mode_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            e0_q         <= e0_d;
            f0_q         <= f0_d;
            dir_q        <= dir_d;
            mode_key_q   <= mode_key_d;
            mode_valid_q <= mode_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef TYPEMATIC_SUPPRESS_EN
    // Held-direction record used to suppress typematic repeats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q <= 4'b0000;
        end else begin
            held_q <= held_d;
        end
    end
`endif

    assign dir        = dir_q;
    assign mode_key   = mode_key_q;
    assign mode_valid = mode_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    logic       clk;
    logic       rst_n;
    logic       PS2C;
    logic       PS2D;
    logic [3:0] dir;
    logic [7:0] mode_key;
    logic       mode_valid;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int cnt_up = 0, cnt_down = 0, cnt_left = 0, cnt_right = 0;
    int cnt_mv = 0, cnt_err = 0, cnt_bad = 0;
    int last_dir_cyc = 0;
    int stop_drop_cyc = 0;
    logic [3:0] prev_dir = 4'b0000;

    ps2_key_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PS2C       (PS2C),
        .PS2D       (PS2D),
        .dir        (dir),
        .mode_key   (mode_key),
        .mode_valid (mode_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        prev_dir <= dir;
        if (dir[3]) cnt_up    <= cnt_up + 1;
        if (dir[2]) cnt_down  <= cnt_down + 1;
        if (dir[1]) cnt_left  <= cnt_left + 1;
        if (dir[0]) cnt_right <= cnt_right + 1;
        if (mode_valid) cnt_mv <= cnt_mv + 1;
        if (frame_err)  cnt_err <= cnt_err + 1;
        if (dir != 4'b0000) last_dir_cyc <= cyc;
        if ((dir != 4'b0000 && $countones(dir) != 1) ||
            (dir != 4'b0000 && prev_dir != 4'b0000) ||
            (dir != 4'b0000 && mode_valid))
            cnt_bad <= cnt_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic is_stop);
        @(negedge clk);
        PS2D = b;
        repeat (10) @(negedge clk);
        PS2C = 1'b0;
        if (is_stop) stop_drop_cyc = cyc;
        repeat (20) @(negedge clk);
        PS2C = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic flip_par);
        logic p;
        p = ~(^data) ^ flip_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i], 1'b0);
        send_bit(p, 1'b0);
        send_bit(1'b1, 1'b1);
        PS2D = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    int s_up, s_down, s_left, s_right, s_mv, s_err;

    task automatic snap();
        s_up = cnt_up; s_down = cnt_down; s_left = cnt_left;
        s_right = cnt_right; s_mv = cnt_mv; s_err = cnt_err;
    endtask

    initial begin
        int exp_down;
        int lat;
        PS2C  = 1'b1;
        PS2D  = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_mode_key", 32'(mode_key), 32'h0);
        check("rst_mode_valid", 32'(mode_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // W make -> up pulse
        snap();
        send_frame(8'h1D, 1'b0);
        check("w_up_pulses", 32'(cnt_up - s_up), 32'd1);
        check("w_no_other_dir", 32'(cnt_down + cnt_left + cnt_right - s_down - s_left - s_right), 32'd0);
        check("w_no_mode_valid", 32'(cnt_mv - s_mv), 32'd0);
        lat = last_dir_cyc - stop_drop_cyc;
        check("w_latency_window", 32'((lat >= 6) && (lat <= 18)), 32'd1);

        // E0 74 make, E0 F0 74 break -> one right pulse
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h74, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        check("ext_right_pulses", 32'(cnt_right - s_right), 32'd1);
        check("ext_no_mode_valid", 32'(cnt_mv - s_mv), 32'd0);
        check("ext_e0_clear", 32'(dut.e0_q), 32'd0);
        check("ext_f0_clear", 32'(dut.f0_q), 32'd0);

        // Mode key 16, then its break
        snap();
        send_frame(8'h16, 1'b0);
        check("mode_key_16", 32'(mode_key), 32'h16);
        check("mode_valid_once", 32'(cnt_mv - s_mv), 32'd1);
        snap();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        check("mode_key_held", 32'(mode_key), 32'h16);
        check("mode_break_no_pulse", 32'(cnt_mv - s_mv), 32'd0);

        // Bad parity, then good A
        snap();
        send_frame(8'h1C, 1'b1);
        check("par_err_once", 32'(cnt_err - s_err), 32'd1);
        check("par_no_dir", 32'(cnt_left - s_left), 32'd0);
        snap();
        send_frame(8'h1C, 1'b0);
        check("a_left_pulse", 32'(cnt_left - s_left), 32'd1);
        check("a_no_err", 32'(cnt_err - s_err), 32'd0);

        // Stall mid-frame -> timeout
        snap();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        PS2D = 1'b1;
        repeat (20100) @(negedge clk);
        check("timeout_err", 32'(cnt_err - s_err), 32'd1);
        check("timeout_idle", 32'(dut.u_rx.state_q), 32'(ps2_pkg::ST_IDLE));
        snap();
        send_frame(8'h23, 1'b0);
        check("after_to_right", 32'(cnt_right - s_right), 32'd1);

        // Typematic repeats of S
        snap();
        send_frame(8'h1B, 1'b0);
        send_frame(8'h1B, 1'b0);
        send_frame(8'h1B, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1B, 1'b0);
        send_frame(8'h1B, 1'b0);
`ifdef TYPEMATIC_SUPPRESS_EN
        exp_down = 2;
`else
        exp_down = 4;
`endif
        check("typematic_down", 32'(cnt_down - s_down), 32'(exp_down));
        check("typematic_no_err", 32'(cnt_err - s_err), 32'd0);

        // Pulse shape and exclusivity over the whole run
        check("pulse_shape", 32'(cnt_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
